// File: rtl/demux_pkg.sv
// Shared constants and FSM state type for the lane scatter demultiplexer.
package demux_pkg;
  localparam int NUM_LANES = 31;
  localparam int DATA_W    = 2;
  localparam int SEL_W     = 5;
  localparam logic [4:0] SEL_INVALID = 5'd31;

  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/demux_lane.sv
// One output lane: data register plus frame-valid flag; data survives clears.
module demux_lane
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_scatter.sv
// Scatters accepted beats into NUM_LANES registered lanes; 1-cycle write latency.
// in_ready drops during reset, frame_clr and the single FLUSH cycle after a full frame.
module demux_scatter
  import demux_pkg::*;
#(
  parameter int NUM_LANES = demux_pkg::NUM_LANES,
  parameter int DATA_W    = demux_pkg::DATA_W,
  parameter int SEL_W     = demux_pkg::SEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 auto_mode,
  input  logic                 frame_clr,
  output logic [DATA_W-1:0]    out0,
  output logic [DATA_W-1:0]    out1,
  output logic [DATA_W-1:0]    out2,
  output logic [DATA_W-1:0]    out3,
  output logic [DATA_W-1:0]    out4,
  output logic [DATA_W-1:0]    out5,
  output logic [DATA_W-1:0]    out6,
  output logic [DATA_W-1:0]    out7,
  output logic [DATA_W-1:0]    out8,
  output logic [DATA_W-1:0]    out9,
  output logic [DATA_W-1:0]    out10,
  output logic [DATA_W-1:0]    out11,
  output logic [DATA_W-1:0]    out12,
  output logic [DATA_W-1:0]    out13,
  output logic [DATA_W-1:0]    out14,
  output logic [DATA_W-1:0]    out15,
  output logic [DATA_W-1:0]    out16,
  output logic [DATA_W-1:0]    out17,
  output logic [DATA_W-1:0]    out18,
  output logic [DATA_W-1:0]    out19,
  output logic [DATA_W-1:0]    out20,
  output logic [DATA_W-1:0]    out21,
  output logic [DATA_W-1:0]    out22,
  output logic [DATA_W-1:0]    out23,
  output logic [DATA_W-1:0]    out24,
  output logic [DATA_W-1:0]    out25,
  output logic [DATA_W-1:0]    out26,
  output logic [DATA_W-1:0]    out27,
  output logic [DATA_W-1:0]    out28,
  output logic [DATA_W-1:0]    out29,
  output logic [DATA_W-1:0]    out30,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic                 frame_done,
  output logic                 sel_err
);

  state_t                state;
  logic [SEL_W-1:0]      wptr;
  logic [SEL_W-1:0]      lane_sel;
  logic [NUM_LANES-1:0]  wr_en;
  logic [DATA_W-1:0]     lane_data [NUM_LANES];
  logic                  accept;
  logic                  sel_bad;
  logic                  lane_clr;
  logic                  fill_done;

  // rst_n gates ready so the source sees 0 throughout reset, 1 right after release
  assign in_ready  = rst_n && (state == FILL) && !frame_clr;
  assign accept    = in_valid && in_ready;
  assign lane_sel  = auto_mode ? wptr : in_sel;
  assign sel_bad   = !auto_mode && (in_sel == SEL_W'(SEL_INVALID));
  assign lane_clr  = frame_clr || (state == FLUSH);
  assign fill_done = accept && !sel_bad && (&(lane_valid | wr_en));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wr_en[i] = accept && !sel_bad && (lane_sel == SEL_W'(i));

    demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[i]),
      .clr     (lane_clr),
      .wr_data (in_data),
      .data    (lane_data[i]),
      .valid   (lane_valid[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wptr       <= '0;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sel_err    <= accept && sel_bad;
      if (frame_clr) begin
        state <= FILL;
        wptr  <= '0;
      end else begin
        case (state)
          FILL: begin
            if (accept && auto_mode)
              wptr <= (wptr == SEL_W'(NUM_LANES - 1)) ? '0 : wptr + 1'b1;
            if (fill_done) begin
              state      <= FLUSH;
              frame_done <= 1'b1;
            end
          end
          FLUSH: begin
            state <= FILL;
            wptr  <= '0;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  assign out0  = lane_data[0];
  assign out1  = lane_data[1];
  assign out2  = lane_data[2];
  assign out3  = lane_data[3];
  assign out4  = lane_data[4];
  assign out5  = lane_data[5];
  assign out6  = lane_data[6];
  assign out7  = lane_data[7];
  assign out8  = lane_data[8];
  assign out9  = lane_data[9];
  assign out10 = lane_data[10];
  assign out11 = lane_data[11];
  assign out12 = lane_data[12];
  assign out13 = lane_data[13];
  assign out14 = lane_data[14];
  assign out15 = lane_data[15];
  assign out16 = lane_data[16];
  assign out17 = lane_data[17];
  assign out18 = lane_data[18];
  assign out19 = lane_data[19];
  assign out20 = lane_data[20];
  assign out21 = lane_data[21];
  assign out22 = lane_data[22];
  assign out23 = lane_data[23];
  assign out24 = lane_data[24];
  assign out25 = lane_data[25];
  assign out26 = lane_data[26];
  assign out27 = lane_data[27];
  assign out28 = lane_data[28];
  assign out29 = lane_data[29];
  assign out30 = lane_data[30];

endmodule
